// File: rtl/conv_pkg.sv
// Shared constants, types and the saturating add used by the channel
// accumulator and its output feature map buffer.
package conv_pkg;

  localparam int OFM_DIM        = 28;
  localparam int N_CHN          = 3;
  localparam int DATA_W         = 8;
  localparam int OFM_WORDS      = 784;
  localparam int TOTAL_CAPTURES = 2352;
  localparam int ADDR_W         = 10;
  localparam int CNT_W          = 12;

  typedef logic [DATA_W-1:0] pix_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } acc_state_e;

  // Unsigned add clamped to all-ones on carry out
  function automatic pix_t sat_add8(input pix_t a, input pix_t b);
    logic [DATA_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[DATA_W]) begin
      return {DATA_W{1'b1}};
    end else begin
      return sum[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/conv_chn_accum_if.sv
// Upstream result/tag bus, status flags and host read port of the
// channel accumulator.
interface conv_chn_accum_if;
  import conv_pkg::*;

  logic       in_valid;
  pix_t       in_result;
  logic [4:0] in_row;
  logic [4:0] in_col;
  logic [1:0] in_chn;
  logic       busy;
  logic       done;
  logic       err;
  logic       rd_en;
  addr_t      rd_addr;
  pix_t       rd_data;
  logic       rd_valid;

  modport master (
    output in_valid, in_result, in_row, in_col, in_chn, rd_en, rd_addr,
    input  busy, done, err, rd_data, rd_valid
  );

  modport slave (
    input  in_valid, in_result, in_row, in_col, in_chn, rd_en, rd_addr,
    output busy, done, err, rd_data, rd_valid
  );

endinterface

// File: rtl/conv_chn_accum_ofm_buf.sv
// 784-word output feature map: one write port, a combinational read for the
// accumulate path and a registered read for the host.
module ofm_buf
  import conv_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  we_i,
  input  addr_t waddr_i,
  input  pix_t  wdata_i,
  input  addr_t raddr_a_i,
  output pix_t  rdata_a_o,
  input  logic  re_i,
  input  addr_t raddr_b_i,
  output pix_t  rdata_b_o
);

  pix_t mem_q [OFM_WORDS];
  pix_t rdata_b_q;

  // Storage is deliberately not reset; channel 0 of each pass overwrites it
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i < addr_t'(OFM_WORDS)) ? mem_q[raddr_a_i] : {DATA_W{1'b0}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_b_q <= {DATA_W{1'b0}};
    end else if (re_i) begin
      rdata_b_q <= (raddr_b_i < addr_t'(OFM_WORDS)) ? mem_q[raddr_b_i] : {DATA_W{1'b0}};
    end
  end

  assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/conv_chn_accum.sv
// Accumulates per-channel window results into the output feature map,
// flags tag errors and serves the finished map through a registered read.
module conv_chn_accum
  import conv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  conv_chn_accum_if.slave bus
);

  acc_state_e state_q;
  cnt_t       cnt_q;
  logic       in_valid_q;
  addr_t      addr_q;
  pix_t       res_q;
  logic [1:0] chn_q;
  logic [1:0] prev_chn_q;
  logic       wr_ok_q;
  logic       busy_q;
  logic       done_q;
  logic       err_q;
  logic       rd_valid_q;

  logic  capture_s;
  logic  range_ok_s;
  logic  order_bad_s;
  logic  we_s;
  logic  re_s;
  addr_t addr_s;
  pix_t  rmw_rdata_s;
  pix_t  wdata_s;

  assign capture_s   = bus.in_valid & ~in_valid_q;
  assign range_ok_s  = (bus.in_row < 5'(OFM_DIM)) && (bus.in_col < 5'(OFM_DIM));
  assign order_bad_s = (bus.in_chn >= 2'(N_CHN)) || (bus.in_chn < prev_chn_q);
  assign addr_s      = addr_t'(bus.in_row) * addr_t'(OFM_DIM) + addr_t'(bus.in_col);
  assign we_s        = (state_q == WR) && wr_ok_q && !clear;
  assign re_s        = (state_q == DONE) && bus.rd_en && !clear;

  // Channel 0 starts a fresh pixel; later channels accumulate with saturation
  always_comb begin
    wdata_s = res_q;
    if (chn_q != 2'd0) begin
      wdata_s = sat_add8(rmw_rdata_s, res_q);
    end else begin
      wdata_s = res_q;
    end
  end

  ofm_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (we_s),
    .waddr_i   (addr_q),
    .wdata_i   (wdata_s),
    .raddr_a_i (addr_q),
    .rdata_a_o (rmw_rdata_s),
    .re_i      (re_s),
    .raddr_b_i (bus.rd_addr),
    .rdata_b_o (bus.rd_data)
  );

  // Control FSM with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 12'd0;
      in_valid_q <= 1'b0;
      addr_q     <= 10'd0;
      res_q      <= 8'd0;
      chn_q      <= 2'd0;
      prev_chn_q <= 2'd0;
      wr_ok_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else if (clear) begin
      state_q    <= IDLE;
      cnt_q      <= 12'd0;
      in_valid_q <= bus.in_valid;
      prev_chn_q <= 2'd0;
      wr_ok_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      in_valid_q <= bus.in_valid;
      rd_valid_q <= 1'b0;
      case (state_q)
        IDLE, RUN: begin
          if (capture_s) begin
            state_q    <= WR;
            busy_q     <= 1'b1;
            addr_q     <= addr_s;
            res_q      <= bus.in_result;
            chn_q      <= bus.in_chn;
            prev_chn_q <= bus.in_chn;
            wr_ok_q    <= range_ok_s;
            cnt_q      <= cnt_q + 12'd1;
            if (!range_ok_s || order_bad_s) begin
              err_q <= 1'b1;
            end
          end
        end
        WR: begin
          busy_q <= 1'b0;
          // A capture here would collide with the in-flight write; drop it
          if (capture_s) begin
            err_q <= 1'b1;
          end
          if (cnt_q == cnt_t'(TOTAL_CAPTURES)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= RUN;
          end
        end
        DONE: begin
          if (capture_s) begin
            err_q <= 1'b1;
          end
          rd_valid_q <= bus.rd_en;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_conv_chn_accum.sv
// Randomized scoreboard bench for conv_chn_accum against a plain-arithmetic
// model of the channel accumulation rules.
module tb_conv_chn_accum;
  import conv_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;

  conv_chn_accum_if bus();

  conv_chn_accum dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  // Reference model state
  int ref_buf[784];
  int ref_prev;
  int ref_cnt;
  bit ref_err;
  bit ref_done;
  int val_a[3][784];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    ref_prev = 0;
    ref_cnt  = 0;
    ref_err  = 1'b0;
    ref_done = 1'b0;
  endfunction

  function automatic void model_capture(input int r, input int c, input int ch, input int v);
    if (ref_done) begin
      ref_err = 1'b1;
      return;
    end
    if (r >= 28 || c >= 28 || ch >= 3 || ch < ref_prev) ref_err = 1'b1;
    ref_cnt++;
    ref_prev = ch;
    if (r < 28 && c < 28) begin
      int a;
      a = r * 28 + c;
      if (ch == 0) ref_buf[a] = v;
      else ref_buf[a] = (ref_buf[a] + v > 255) ? 255 : ref_buf[a] + v;
    end
    if (ref_cnt == 2352) ref_done = 1'b1;
  endfunction

  task automatic drive_tag(input int r, input int c, input int ch, input int v);
    bus.in_row    = 5'(r);
    bus.in_col    = 5'(c);
    bus.in_chn    = 2'(ch);
    bus.in_result = 8'(v);
    bus.in_valid  = 1'b1;
  endtask

  task automatic send(input int r, input int c, input int ch, input int v, input bit chk);
    @(posedge clk); #1;
    drive_tag(r, c, ch, v);
    model_capture(r, c, ch, v);
    @(posedge clk); @(negedge clk);
    if (chk) begin
      check("busy_in_wr", 32'(bus.busy), 1);
      check("done_in_wr", 32'(bus.done), 0);
    end
    @(posedge clk); @(negedge clk);
    if (chk) begin
      check("busy_after_wr", 32'(bus.busy), 0);
      check("done_after_wr", 32'(bus.done), 32'(ref_done));
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic hold_send(input int r, input int c, input int ch, input int v);
    int n = 0;
    @(posedge clk); #1;
    drive_tag(r, c, ch, v);
    model_capture(r, c, ch, v);
    repeat (10) begin
      @(negedge clk);
      if (bus.busy === 1'b1) n++;
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    check("hold_single_capture", n, 1);
  endtask

  task automatic rd(input int a, input bit want);
    @(posedge clk); #1;
    bus.rd_en   = 1'b1;
    bus.rd_addr = 10'(a);
    if (want) exp_q.push_back((a < 784) ? ref_buf[a] : 0);
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
    if (!want) begin
      @(negedge clk);
      check("rd_valid_outside_done", 32'(bus.rd_valid), 0);
    end
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_reset();
    @(negedge clk);
    check("clear_done", 32'(bus.done), 0);
    check("clear_err", 32'(bus.err), 0);
    check("clear_busy", 32'(bus.busy), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_rd_valid", 32'(bus.rd_valid), 0);
    check("rst_rd_data", 32'(bus.rd_data), 0);
  endtask

  // Scoreboard monitor: every presented read word must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected: got rd_valid=1, want 0");
      end else begin
        int e;
        e = exp_q.pop_front();
        check("rd_data", 32'(bus.rd_data), e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_result = 8'd0;
    bus.in_row    = 5'd0;
    bus.in_col    = 5'd0;
    bus.in_chn    = 2'd0;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = 10'd0;
    model_reset();
    foreach (ref_buf[i]) ref_buf[i] = 0;

    #12;
    check_reset_outputs();
    #11;
    rst_n = 1'b1;

    // Pass A: random map with directed pixels for sum, saturation and held level
    for (int ch = 0; ch < 3; ch++)
      for (int p = 0; p < 784; p++)
        val_a[ch][p] = int'($urandom_range(0, 255));
    val_a[0][0]   = 100; val_a[1][0]   = 100; val_a[2][0]   = 50;
    val_a[0][147] = 200; val_a[1][147] = 100; val_a[2][147] = 10;
    val_a[0][148] = 255; val_a[1][148] = 0;   val_a[2][148] = 0;
    val_a[0][29]  = 7;   val_a[1][29]  = 0;   val_a[2][29]  = 0;
    for (int ch = 0; ch < 3; ch++) begin
      for (int p = 0; p < 784; p++) begin
        if (ch == 0 && p == 29) hold_send(p / 28, p % 28, ch, val_a[ch][p]);
        else send(p / 28, p % 28, ch, val_a[ch][p], (ch == 2 && p == 783) || (ch == 1 && p == 5));
      end
    end
    check("passA_err", 32'(bus.err), 0);
    check("passA_done", 32'(bus.done), 1);
    rd(0, 1'b1);
    rd(147, 1'b1);
    rd(148, 1'b1);
    rd(29, 1'b1);
    rd(783, 1'b1);
    rd(800, 1'b1);
    repeat (4) rd(int'($urandom_range(0, 783)), 1'b1);

    // A capture after completion is ignored but flagged
    send(3, 3, 0, 9, 1'b0);
    check("capture_in_done_err", 32'(bus.err), 1);
    rd(87, 1'b1);
    do_clear();

    // Pass B: partial pass interrupted by reset
    for (int p = 0; p < 500; p++) begin
      send(p / 28, p % 28, 0, int'($urandom_range(0, 255)), 1'b0);
      if (p == 100) rd(5, 1'b0);
    end
    @(negedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    rd(0, 1'b0);

    // Full ordered pass with value row+col per channel
    for (int ch = 0; ch < 3; ch++) begin
      for (int p = 0; p < 784; p++) begin
        if (ch == 1 && p == 0) rd(10, 1'b0);
        send(p / 28, p % 28, ch, p / 28 + p % 28, (ch == 2 && p == 783) || p == 400);
      end
    end
    check("passB_err", 32'(bus.err), 0);
    rd(783, 1'b1);
    rd(0, 1'b1);
    rd(29, 1'b1);
    repeat (3) rd(int'($urandom_range(0, 1023)), 1'b1);
    do_clear();

    // Error flag: out-of-range row, then descending channel
    send(28, 0, 0, 1, 1'b0);
    check("err_row_range", 32'(bus.err), 32'(ref_err));
    send(0, 0, 0, 1, 1'b0);
    check("err_sticky", 32'(bus.err), 1);
    do_clear();
    send(0, 0, 2, 1, 1'b0);
    check("err_chn2_first", 32'(bus.err), 0);
    send(0, 0, 1, 1, 1'b0);
    check("err_chn_descend", 32'(bus.err), 32'(ref_err));
    do_clear();

    repeat (5) @(posedge clk);
    check("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_chn_accum.md
Name: conv_chn_accum

Overview:
- Downstream stage of `convolve`. Captures each per-channel 8-bit window result together with its (row, col, chn) tag.
- Sums results across input channels per output pixel, saturating at 255, into a 28x28 output feature map (OFM) buffer.
- Signals completion when the full map is accumulated, then exposes the OFM through a registered read port for the host/bus side.

Parameters:
- OFM_DIM, 28, output map height/width in pixels.
- N_CHN, 3, input channels accumulated per pixel.
- DATA_W, 8, result and accumulator width (unsigned).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- clear  in  1  synchronous pulse; aborts any pass, returns to IDLE
- in_valid  in  1  upstream result-ready level (`convolve` ready); sampled on its rising edge
- in_result  in  DATA_W  window result for one channel
- in_row  in  5  output row of in_result
- in_col  in  5  output column of in_result
- in_chn  in  2  channel of in_result
- busy  out  1  high while a read-modify-write is in flight
- done  out  1  high in DONE state
- err  out  1  sticky; coordinate out of range or channel out of order
- rd_en  in  1  read request (honoured in DONE only)
- rd_addr  in  10  linear address row*OFM_DIM+col
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  rd_data valid, one cycle after accepted rd_en

Behaviour:
- Reset values: busy=0, done=0, err=0, rd_data=0, rd_valid=0, state=IDLE, capture counter=0.
  - Buffer contents are not reset; channel 0 overwrites them.
- Capture: register in_valid each cycle; a capture event is in_valid=1 while in_valid_q=0.
  - A level held high for many cycles is exactly one capture.
  - Tag and result are sampled in the event cycle.
- Channel write rule (next cycle after capture, state WR):
  - in_chn==0: buf[addr] <= in_result.
  - else: sum = buf[addr] + in_result in DATA_W+1 bits; write 8'hFF if sum>255, else sum[7:0].
  - busy=1 during WR only.
- Latency: captured value is visible in the buffer 2 cycles after the in_valid rising edge.
- FSM:
  - IDLE: first capture -> WR, then RUN.
  - RUN: capture -> WR -> RUN.
  - When capture count reaches N_CHN*OFM_DIM*OFM_DIM (2352), WR -> DONE.
  - DONE: done=1; further captures ignored and set err.
  - clear from any state -> IDLE next cycle; counter=0, err=0, done=0.
- Ordering check: err sets if
  - in_row>=OFM_DIM or in_col>=OFM_DIM (write suppressed, capture still counted), or
  - in_chn>=N_CHN, or
  - in_chn is lower than the chn of the previous capture.
- Simultaneous events:
  - Capture during WR cannot occur, since upstream needs >=2 cycles per toggle.
  - If it does, the capture is dropped and err sets.
  - clear beats capture in the same cycle.
- Read port:
  - In DONE with rd_en=1: rd_data<=buf[rd_addr] and rd_valid=1 on the next cycle.
  - rd_addr>=784 returns 0.
  - rd_en outside DONE is ignored (rd_valid stays 0).
- Reset asserted mid-pass: immediate return to IDLE, outputs to reset values; the next pass overwrites through channel 0.

Decomposition:
- Shared package `conv_pkg`:
  - constants OFM_DIM=28, N_CHN=3, DATA_W=8, OFM_WORDS=784, TOTAL_CAPTURES=2352;
  - typedef `pix_t` logic [DATA_W-1:0];
  - `acc_state_e` {IDLE, RUN, WR, DONE};
  - function `sat_add8`.
- One sub-module `ofm_buf`: 784 x DATA_W storage with one write port and two read ports (combinational RMW read, registered host read).

Test Plan:
- Single pixel (0,0): chn0=100, chn1=100, chn2=50 -> rd_addr 0 returns 250, err=0.
- Saturation at (5,7): 200+100+10 -> rd_addr 147 returns 255; 255+0+0 returns 255.
- Full pass (2352 ordered captures, value row+col per channel) -> done rises exactly after the last WR; rd_addr 783 returns 162.
- in_valid held high 10 cycles with one value 7 at (1,1) chn0 -> single capture; buf[29]=7, count=1.
- Out-of-range (row=28) and chn descending 2->1 -> err=1 and stays until clear; clear -> done=0, err=0, IDLE.
- Reset asserted after 500 captures, then a full pass -> correct results with no residue; rd_en before done gives rd_valid=0.
